// File: rtl/cdc_hs_resp.sv
// cdc_hs_resp: four-phase handshake responder.
// The initiator's req_in is asynchronous to clk. It is synchronized, and then
// a three-state FSM captures the bundled data word, offers it downstream with
// a valid/ready pair, and returns a registered four-phase acknowledge.
// The module also counts completed transfers and keeps a sticky flag that is
// set when the initiator withdraws its request before being acknowledged.
module cdc_hs_resp #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [7:0]        xfer_cnt,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request synchronizer. Only req_s is used downstream of this point.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   req_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = req_in;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign req_s = sync_q[SYNC_STAGES-1];

    // Shift the raw request through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Responder FSM and its registered outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic              capture;     // IDLE -> HOLD: latch data_in
    logic              release_evt; // ACK -> IDLE: transfer completed
    logic              err_evt;     // HOLD -> IDLE: request withdrawn early

    logic              ack_q;
    logic              ack_d;
    logic              dout_valid_q;
    logic              dout_valid_d;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic [7:0]        xfer_cnt_q;
    logic [7:0]        xfer_cnt_d;
    logic              proto_err_q;
    logic              proto_err_d;

    // State register together with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            xfer_cnt_q   <= 8'd0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            dout_valid_q <= dout_valid_d;
            dout_q       <= dout_d;
            xfer_cnt_q   <= xfer_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Next-state logic. Leaving ACK requires req_s low, so a request that is
    // held high permanently can never start a second capture.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        release_evt = 1'b0;
        err_evt     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_HOLD;
                    capture = 1'b1;
                end
            end
            S_HOLD: begin
                // A withdrawn request overrides a same-cycle delivery.
                if (!req_s) begin
                    state_d = S_IDLE;
                    err_evt = 1'b1;
                end else if (dout_ready) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    state_d     = S_IDLE;
                    release_evt = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle. They are derived from the next state
    // so that ack_out and dout_valid come straight from flops.
    always_comb begin
        ack_d        = (state_d == S_ACK);
        dout_valid_d = (state_d == S_HOLD);
        dout_d       = capture ? data_in : dout_q;
        xfer_cnt_d   = release_evt ? (xfer_cnt_q + 8'd1) : xfer_cnt_q;
        proto_err_d  = proto_err_q | err_evt;
    end

    assign ack_out    = ack_q;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign xfer_cnt   = xfer_cnt_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_cdc_hs_resp.sv
// Testbench for cdc_hs_resp (DATA_W=8, SYNC_STAGES=2).
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled 1 time unit after the following rising edge.
module tb_cdc_hs_resp;

    logic       clk;
    logic       rst;
    logic       req_in;
    logic [7:0] data_in;
    logic       ack_out;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [7:0] xfer_cnt;
    logic       proto_err;

    int total;
    int bad;

    cdc_hs_resp #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .xfer_cnt   (xfer_cnt),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic       rst;
        logic       req;
        logic [7:0] data;
        logic       rdy;
        logic       ack;
        logic [7:0] dout;
        logic       valid;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[80];
    int   nvec;

    task automatic add(input logic r, input logic q, input logic [7:0] d, input logic y,
                       input logic a, input logic [7:0] o, input logic v,
                       input logic [7:0] c, input logic e);
        vecs[nvec] = '{rst:r, req:q, data:d, rdy:y, ack:a, dout:o, valid:v, cnt:c, err:e};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_in = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // A single clean transfer with dout_ready=1. Every wait is bounded.
    task automatic do_xfer(input logic [7:0] d, input logic [7:0] exp_cnt, input bit verbose);
        int n;
        req_in = 1'b1;
        data_in = d;
        n = 0;
        while (!dout_valid && n < 10) begin step(); n++; end
        chk("xfer_valid_seen", {31'd0, dout_valid}, 32'd1);
        chk("xfer_dout", {24'd0, dout}, {24'd0, d});
        n = 0;
        while (!ack_out && n < 10) begin step(); n++; end
        chk("xfer_ack_seen", {31'd0, ack_out}, 32'd1);
        req_in = 1'b0;
        n = 0;
        while (ack_out && n < 10) begin step(); n++; end
        chk("xfer_ack_drop", {31'd0, ack_out}, 32'd0);
        chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        if (verbose)
            $display("xfer data=%02h cnt=%0d", d, xfer_cnt);
    endtask

    initial begin
        int pulses;
        total = 0;
        bad = 0;
        nvec = 0;
        rst = 1'b1;
        req_in = 1'b0;
        data_in = 8'h00;
        dout_ready = 1'b0;

        // ---------------- table construction ----------------
        //   rst req data   rdy  ack dout  val cnt  err
        // Reset state
        add(1, 0, 8'h00, 1,  0, 8'h00, 0, 8'd0, 0);
        // Basic transfer of 0xA5: the capture lands two edges after req is seen
        add(0, 1, 8'hA5, 1,  0, 8'h00, 0, 8'd0, 0);
        add(0, 1, 8'hA5, 1,  0, 8'h00, 0, 8'd0, 0);
        add(0, 1, 8'hA5, 1,  0, 8'hA5, 1, 8'd0, 0);
        add(0, 1, 8'hA5, 1,  1, 8'hA5, 0, 8'd0, 0);
        add(0, 0, 8'h00, 1,  1, 8'hA5, 0, 8'd0, 0);
        add(0, 0, 8'h00, 1,  1, 8'hA5, 0, 8'd0, 0);
        add(0, 0, 8'h00, 1,  0, 8'hA5, 0, 8'd1, 0);
        // Backpressure: 0x3C held for 10 cycles with dout_ready=0
        add(0, 1, 8'h3C, 0,  0, 8'hA5, 0, 8'd1, 0);
        add(0, 1, 8'h3C, 0,  0, 8'hA5, 0, 8'd1, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 8'h3C, 0,  0, 8'h3C, 1, 8'd1, 0);
        add(0, 1, 8'h3C, 1,  1, 8'h3C, 0, 8'd1, 0);
        add(0, 0, 8'h00, 1,  1, 8'h3C, 0, 8'd1, 0);
        add(0, 0, 8'h00, 1,  1, 8'h3C, 0, 8'd1, 0);
        add(0, 0, 8'h00, 1,  0, 8'h3C, 0, 8'd2, 0);
        // Protocol error: req drops in HOLD. dout_ready rises on the edge where
        // the withdrawal is first seen, and the error must still win.
        add(0, 1, 8'h5A, 0,  0, 8'h3C, 0, 8'd2, 0);
        add(0, 1, 8'h5A, 0,  0, 8'h3C, 0, 8'd2, 0);
        add(0, 1, 8'h5A, 0,  0, 8'h5A, 1, 8'd2, 0);
        add(0, 0, 8'h5A, 0,  0, 8'h5A, 1, 8'd2, 0);
        add(0, 0, 8'h5A, 0,  0, 8'h5A, 1, 8'd2, 0);
        add(0, 0, 8'h5A, 1,  0, 8'h5A, 0, 8'd2, 1);
        add(0, 0, 8'h00, 1,  0, 8'h5A, 0, 8'd2, 1);
        // A clean transfer after the error still completes; the flag stays sticky
        add(0, 1, 8'hD7, 1,  0, 8'h5A, 0, 8'd2, 1);
        add(0, 1, 8'hD7, 1,  0, 8'h5A, 0, 8'd2, 1);
        add(0, 1, 8'hD7, 1,  0, 8'hD7, 1, 8'd2, 1);
        add(0, 1, 8'hD7, 1,  1, 8'hD7, 0, 8'd2, 1);
        add(0, 0, 8'h00, 1,  1, 8'hD7, 0, 8'd2, 1);
        add(0, 0, 8'h00, 1,  1, 8'hD7, 0, 8'd2, 1);
        add(0, 0, 8'h00, 1,  0, 8'hD7, 0, 8'd3, 1);

        // ---------------- apply table ----------------
        @(negedge clk);
        for (int i = 0; i < nvec; i++) begin
            rst = vecs[i].rst;
            req_in = vecs[i].req;
            data_in = vecs[i].data;
            dout_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_ack", i),   {31'd0, ack_out},    {31'd0, vecs[i].ack});
            chk($sformatf("vec%0d_dout", i),  {24'd0, dout},       {24'd0, vecs[i].dout});
            chk($sformatf("vec%0d_valid", i), {31'd0, dout_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("vec%0d_cnt", i),   {24'd0, xfer_cnt},   {24'd0, vecs[i].cnt});
            chk($sformatf("vec%0d_err", i),   {31'd0, proto_err},  {31'd0, vecs[i].err});
            $display("vec %0d req=%b data=%02h rdy=%b -> ack=%b dout=%02h valid=%b cnt=%0d err=%b",
                     i, req_in, data_in, dout_ready, ack_out, dout, dout_valid, xfer_cnt, proto_err);
        end

        // ---------------- wrap: 256 clean transfers ----------------
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 256; i++)
            do_xfer(8'(i * 7 + 1), 8'((i + 1) % 256), (i < 2) || (i > 253));
        chk("wrap_cnt_zero", {24'd0, xfer_cnt}, 32'd0);
        chk("wrap_err_clear", {31'd0, proto_err}, 32'd0);
        $display("wrap done cnt=%0d err=%b", xfer_cnt, proto_err);

        // ---------------- reset while in ACK ----------------
        do_xfer(8'h11, 8'd1, 1'b1);
        req_in = 1'b1;
        data_in = 8'h42;
        for (int n = 0; n < 10 && !ack_out; n++) step();
        chk("rst_mid_ack_pre", {31'd0, ack_out}, 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_ack_ack", {31'd0, ack_out}, 32'd0);
        chk("rst_mid_ack_cnt", {24'd0, xfer_cnt}, 32'd0);
        chk("rst_mid_ack_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_mid_ack_dout", {24'd0, dout}, 32'd0);
        $display("reset mid-ACK ack=%b cnt=%0d", ack_out, xfer_cnt);
        // req_in still high at release: treated as a new request after 2 syncs.
        rst = 1'b0;
        data_in = 8'h77;
        step();
        step();
        chk("post_rst_wait", {31'd0, dout_valid}, 32'd0);
        step();
        chk("post_rst_valid", {31'd0, dout_valid}, 32'd1);
        chk("post_rst_dout", {24'd0, dout}, 32'h77);
        $display("post-reset capture dout=%02h valid=%b", dout, dout_valid);

        // ---------------- stuck request ----------------
        do_reset();
        dout_ready = 1'b1;
        req_in = 1'b1;
        data_in = 8'h9E;
        pulses = 0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (dout_valid) pulses++;
        end
        chk("stuck_pulses", pulses, 32'd1);
        chk("stuck_ack", {31'd0, ack_out}, 32'd1);
        chk("stuck_dout", {24'd0, dout}, 32'h9E);
        chk("stuck_cnt", {24'd0, xfer_cnt}, 32'd0);
        $display("stuck request pulses=%0d ack=%b", pulses, ack_out);
        req_in = 1'b0;
        for (int n = 0; n < 10 && ack_out; n++) step();
        chk("stuck_release_cnt", {24'd0, xfer_cnt}, 32'd1);
        chk("stuck_release_ack", {31'd0, ack_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
